// File: rtl/turkey_tally_if.sv
// Signal bundle between the turkey-crossing event source and the tally block.
// The master drives the events and clear and observes the count and LED outputs.
interface turkey_tally_if #(
  parameter int WIDTH = 8
);
  logic             turkey_right;
  logic             turkey_left;
  logic             clear;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] magnitude;
  logic             negative;
  logic             right_led;
  logic             left_led;
  logic             overflow;

  modport master (
    output turkey_right, turkey_left, clear,
    input  count, magnitude, negative, right_led, left_led, overflow
  );

  modport slave (
    input  turkey_right, turkey_left, clear,
    output count, magnitude, negative, right_led, left_led, overflow
  );
endinterface

// File: rtl/turkey_tally.sv
// Net turkey-crossing counter: right = +1, left = -1, edge-detected events,
// saturating or wrapping limits, sign/magnitude view and stretched direction LEDs.
module turkey_tally #(
  parameter int WIDTH          = 8,
  parameter bit SATURATE       = 1'b1,
  parameter int STRETCH_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          reset,
  turkey_tally_if.slave bus
);
  localparam int CW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  // Bit 0 is the right direction, bit 1 the left direction.
  logic [1:0]       ev_q_reg;
  logic [1:0]       ev_d_reg;
  logic [1:0]       step;
  logic [1:0]       led;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             overflow_reg;
  logic             overflow_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ev_q_reg <= '0;
      ev_d_reg <= '0;
    end else begin
      ev_q_reg <= {bus.turkey_left, bus.turkey_right};
      ev_d_reg <= ev_q_reg;
    end
  end

  assign step = ev_q_reg & ~ev_d_reg;

  // Simultaneous right and left steps cancel; clear discards any pending step.
  always_comb begin
    count_next    = count_reg;
    overflow_next = overflow_reg;
    if (bus.clear) begin
      count_next    = '0;
      overflow_next = 1'b0;
    end else if (step == 2'b01) begin
      if (count_reg == MAX_V) begin
        overflow_next = 1'b1;
        count_next    = SATURATE ? MAX_V : MIN_V;
      end else begin
        count_next = count_reg + WIDTH'(1);
      end
    end else if (step == 2'b10) begin
      if (count_reg == MIN_V) begin
        overflow_next = 1'b1;
        count_next    = SATURATE ? MIN_V : MAX_V;
      end else begin
        count_next = count_reg - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Each stretcher reloads on a new step, so a lit LED is extended, never blinked off.
  for (genvar gi = 0; gi < 2; gi++) begin : g_stretch
    logic [CW-1:0] stretch_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stretch_reg <= '0;
      end else if (bus.clear) begin
        stretch_reg <= '0;
      end else if (step[gi]) begin
        stretch_reg <= CW'(STRETCH_CYCLES);
      end else if (stretch_reg != '0) begin
        stretch_reg <= stretch_reg - CW'(1);
      end
    end

    assign led[gi] = (stretch_reg != '0);
  end

  // Negating the most negative count yields 2^(WIDTH-1), which still fits unsigned.
  assign bus.count     = count_reg;
  assign bus.negative  = count_reg[WIDTH-1];
  assign bus.magnitude = count_reg[WIDTH-1] ? (~count_reg + WIDTH'(1)) : count_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.right_led = led[0];
  assign bus.left_led  = led[1];
endmodule
